obsidian_decode_stage: RTL and testbench

OBSIDIAN_DECODE_STAGE -- requirements
Module: obsidian_decode_stage

---
 rtl/obsidian_pkg.sv | 37 +++
 rtl/obsidian_regfile.sv | 45 ++++
 rtl/obsidian_decode_stage.sv | 140 ++++++++++++++
 tb/tb_obsidian_decode_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obsidian_pkg.sv
// Shared opcode, funct and ALU control encodings for the obsidian pipeline.
// Decode produces these codes and the ALU stage consumes them.
package obsidian_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    typedef enum logic [2:0] {
        ALU_OR  = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SUB = 3'b100,
        ALU_SRA = 3'b101
    } alu_op_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     alu;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        dest_wr;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/obsidian_regfile.sv
// Register file: two combinational read ports, one write port.
// A same-cycle write to a read address is forwarded to that read port.
module obsidian_regfile #(
    parameter int REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);
    localparam int AW = $clog2(REG_COUNT);

    logic [31:0] regs [REG_COUNT];
    logic        wr;

    assign wr = we && (waddr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a[AW-1:0]];
        if (raddr_a == 5'd0) rdata_a = 32'd0;
        else if (wr && waddr == raddr_a) rdata_a = wdata;
    end

    always_comb begin
        rdata_b = regs[raddr_b[AW-1:0]];
        if (raddr_b == 5'd0) rdata_b = 32'd0;
        else if (wr && waddr == raddr_b) rdata_b = wdata;
    end

endmodule

// File: rtl/obsidian_decode_stage.sv
// Decode stage: field split, register read with write-back bypass,
// and a single-entry registered output with valid/ready handshake.
module obsidian_decode_stage
    import obsidian_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  alu_control,
    output logic [4:0]  shamt,
    output logic [4:0]  dest,
    output logic        dest_wr,
    output logic        illegal
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sh     = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    obsidian_regfile #(
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rs_val),
        .raddr_b (rt),
        .rdata_b (rt_val)
    );

    logic    legal;
    logic    rtype;
    logic    sext;
    alu_op_t op;

    always_comb begin
        legal = 1'b1;
        rtype = 1'b0;
        sext  = 1'b0;
        op    = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                rtype = 1'b1;
                unique case (funct)
                    FN_OR:   op = ALU_OR;
                    FN_ADD:  op = ALU_ADD;
                    FN_AND:  op = ALU_AND;
                    FN_XOR:  op = ALU_XOR;
                    FN_SUB:  op = ALU_SUB;
                    FN_SRA:  op = ALU_SRA;
                    default: legal = 1'b0;
                endcase
            end
            OP_ORI:  op = ALU_OR;
            OP_ADDI: begin
                op   = ALU_ADD;
                sext = 1'b1;
            end
            OP_ANDI: op = ALU_AND;
            OP_XORI: op = ALU_XOR;
            default: legal = 1'b0;
        endcase
    end

    dec_t dec;

    // Illegal encodings issue as a harmless ADD 0,0 with no write-back.
    always_comb begin
        dec         = '0;
        dec.alu     = op;
        dec.illegal = !legal;
        if (legal) begin
            dec.a = rs_val;
            if (rtype) dec.b = rt_val;
            else if (sext) dec.b = {{16{imm[15]}}, imm};
            else dec.b = {16'd0, imm};
            dec.dest    = rtype ? rd : rt;
            dec.shamt   = (op == ALU_SRA) ? sh : 5'd0;
            dec.dest_wr = (dec.dest != 5'd0);
        end
    end

    dec_t q;
    logic capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            q         <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign a           = q.a;
    assign b           = q.b;
    assign alu_control = q.alu;
    assign shamt       = q.shamt;
    assign dest        = q.dest;
    assign dest_wr     = q.dest_wr;
    assign illegal     = q.illegal;

endmodule

// File: tb/tb_obsidian_decode_stage.sv
// Directed bench for obsidian_decode_stage.
// Outputs are sampled 1ns after the rising edge.
module tb_obsidian_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_control;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        dest_wr;
    logic        illegal;

    int tests;
    int fails;

    obsidian_decode_stage #(.REG_COUNT(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .shamt       (shamt),
        .dest        (dest),
        .dest_wr     (dest_wr),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, a, b, alu_control, shamt, dest, dest_wr, illegal}
    logic [79:0] obs;
    logic [79:0] exp;
    assign obs = {out_valid, a, b, alu_control, shamt, dest, dest_wr, illegal};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        exp = 80'd0;
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=%h", obs, exp);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        step();
        wb_addr = 5'd2; wb_data = 32'd3;
        step();
        wb_en = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd5, 32'd3, 3'b001, 5'd0, 5'd3, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL add_r1_r2 got=%h want=%h", obs, exp);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL add_consumed got=%b want=0", out_valid);
        end
    endtask

    task automatic test_imm();
        in_valid = 1'b1;
        instr = itype(6'h08, 5'd0, 5'd4, 16'hFFFF);
        step();
        exp = {1'b1, 32'd0, 32'hFFFF_FFFF, 3'b001, 5'd0, 5'd4, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL addi_sext got=%h want=%h", obs, exp);
        end
        instr = itype(6'h0D, 5'd0, 5'd4, 16'hFFFF);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd0, 32'h0000_FFFF, 3'b000, 5'd0, 5'd4, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL ori_zext got=%h want=%h", obs, exp);
        end
        in_valid = 1'b1;
        instr = itype(6'h0E, 5'd2, 5'd9, 16'h8001);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd3, 32'h0000_8001, 3'b011, 5'd0, 5'd9, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL xori_zext got=%h want=%h", obs, exp);
        end
        step();
    endtask

    task automatic test_sra();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h8000_0000;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1;
        instr = rtype(5'd0, 5'd1, 5'd5, 5'd4, 6'h03);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd0, 32'h8000_0000, 3'b101, 5'd4, 5'd5, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL sra_shamt got=%h want=%h", obs, exp);
        end
        in_valid = 1'b1;
        instr = rtype(5'd2, 5'd2, 5'd0, 5'd7, 6'h24);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd3, 32'd3, 3'b010, 5'd0, 5'd0, 1'b0, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL and_dest0 got=%h want=%h", obs, exp);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [79:0] x_exp;
        x_exp = {1'b1, 32'd3, 32'd3, 3'b011, 5'd0, 5'd6, 1'b1, 1'b0};
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = rtype(5'd2, 5'd2, 5'd6, 5'd0, 6'h26);
        step();
        instr = rtype(5'd2, 5'd0, 5'd8, 5'd0, 6'h22);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0 || obs !== x_exp) begin
                fails++;
                $display("FAIL stall_hold[%0d] in_ready=%b got=%h want=%h",
                         i, in_ready, obs, x_exp);
            end
            step();
        end
        tests++;
        if (obs !== x_exp) begin
            fails++;
            $display("FAIL stall_end got=%h want=%h", obs, x_exp);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready got=%b want=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd3, 32'd0, 3'b100, 5'd0, 5'd8, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL stall_next got=%h want=%h", obs, exp);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_no_dup got=%b want=0", out_valid);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        in_valid = 1'b1;
        instr = rtype(5'd7, 5'd0, 5'd9, 5'd0, 6'h20);
        step();
        exp = {1'b1, 32'h1234, 32'd0, 3'b001, 5'd0, 5'd9, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL bypass_r7 got=%h want=%h", obs, exp);
        end
        wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        instr = rtype(5'd0, 5'd7, 5'd10, 5'd0, 6'h25);
        step();
        wb_en = 1'b0;
        instr = rtype(5'd0, 5'd0, 5'd11, 5'd0, 6'h20);
        exp = {1'b1, 32'd0, 32'h1234, 3'b000, 5'd0, 5'd10, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL bypass_r0 got=%h want=%h", obs, exp);
        end
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd0, 32'd0, 3'b001, 5'd0, 5'd11, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL r0_reads_zero got=%h want=%h", obs, exp);
        end
        step();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1;
        instr = {6'h3F, 5'd1, 5'd2, 16'h1234};
        step();
        exp = {1'b1, 32'd0, 32'd0, 3'b001, 5'd0, 5'd0, 1'b0, 1'b1};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL illegal_op got=%h want=%h", obs, exp);
        end
        instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3A);
        step();
        in_valid = 1'b0;
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL illegal_funct got=%h want=%h", obs, exp);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h77;
        step();
        flush = 1'b0;
        wb_en = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_empty got=%b want=0", out_valid);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || dest !== 5'd3) begin
            fails++;
            $display("FAIL flush_recapture valid=%b dest=%0d want 1/3", out_valid, dest);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_held got=%b want=0", out_valid);
        end
        instr = rtype(5'd12, 5'd0, 5'd13, 5'd0, 6'h20);
        step();
        tests++;
        if (a !== 32'h77 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_wb_kept a=%h want=00000077", a);
        end
    endtask

    task automatic test_reset_mid();
        step();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_stall valid=%b ready=%b", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hFF;
        #1;
        exp = 80'd0;
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_async got=%h want=%h", obs, exp);
        end
        step();
        wb_en = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        instr = rtype(5'd1, 5'd12, 5'd3, 5'd0, 6'h20);
        step();
        in_valid = 1'b0;
        exp = {1'b1, 32'd0, 32'd0, 3'b001, 5'd0, 5'd3, 1'b1, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL regs_cleared got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        instr = 32'd0;
        wb_en = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_imm();
        test_sra();
        test_back_to_back();
        test_bypass();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
